// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extension stage (ID->EX) with a
// 2-entry skid buffer, valid/ready handshake and synchronous flush.
// Modes: 00 sign, 01 zero, 10 upper (LUI), 11 branch (sext << 2).
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Branch mode needs two spare bits above the immediate for the shift.
    generate
        if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_params
            $error("imm_ext_pipe: require IN_W >= 2 and OUT_W >= IN_W + 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Widen an immediate according to the requested mode.
    function automatic logic [OUT_W-1:0] ext_imm(input logic [IN_W-1:0] imm,
                                                 input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            2'b00:   ext_imm = sext;
            2'b01:   ext_imm = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b10:   ext_imm = {imm, {(OUT_W-IN_W){1'b0}}};
            2'b11:   ext_imm = {sext[OUT_W-3:0], 2'b00};
            default: ext_imm = sext;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   main_data_q, main_data_d;
    logic [TAG_W-1:0]   main_tag_q,  main_tag_d;
    logic [OUT_W-1:0]   skid_data_q, skid_data_d;
    logic [TAG_W-1:0]   skid_tag_q,  skid_tag_d;

    logic               in_fire_s;
    logic               load_main_s;
    logic               load_skid_s;
    logic               move_skid_s;
    logic [OUT_W-1:0]   ext_data_s;

    // Flush and reset both block acceptance so nothing slips in while squashing.
    assign in_ready   = (state_q != ST_FULL) & ~flush & ~reset;
    assign in_fire_s  = in_valid & in_ready;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_data_q;
    assign out_tag    = main_tag_q;
    assign ext_data_s = ext_imm(in_imm, in_mode);

    // Next-state and register-load decode; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = ST_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_ready) begin
                        state_d     = ST_ONE;
                        load_main_s = 1'b1;
                    end else if (in_fire_s) begin
                        state_d     = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_d     = ST_ONE;
                        move_skid_s = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Next values of the main (output) and skid registers.
    always_comb begin
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        if (flush) begin
            main_data_d = {OUT_W{1'b0}};
            main_tag_d  = {TAG_W{1'b0}};
            skid_data_d = {OUT_W{1'b0}};
            skid_tag_d  = {TAG_W{1'b0}};
        end else if (load_main_s) begin
            main_data_d = ext_data_s;
            main_tag_d  = in_tag;
        end else if (move_skid_s) begin
            main_data_d = skid_data_q;
            main_tag_d  = skid_tag_q;
        end else if (load_skid_s) begin
            skid_data_d = ext_data_s;
            skid_tag_d  = in_tag;
        end else begin
            main_data_d = main_data_q;
        end
    end

    // State and storage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= {OUT_W{1'b0}};
            main_tag_q  <= {TAG_W{1'b0}};
            skid_data_q <= {OUT_W{1'b0}};
            skid_tag_q  <= {TAG_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed steps plus a scoreboard
// queue filled on in_fire and drained on out_fire.
module tb_imm_ext_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int          n_vec = 0;
    int          n_err = 0;
    logic [36:0] q[$];
    bit          last_in_fire;
    bit          last_out_fire;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension written with signed arithmetic.
    function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
        logic signed [31:0] s;
        s = 32'($signed(imm));
        case (mode)
            2'b00:   return s;
            2'b01:   return 32'(imm);
            2'b10:   return {imm, 16'h0000};
            default: return s * 32'sd4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check handshake outputs, update scoreboard, advance.
    task automatic step();
        logic [36:0] e;
        #1;
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2 && !flush && !reset));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        last_in_fire  = in_valid && in_ready;
        last_out_fire = out_valid && out_ready;
        if (last_out_fire) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e[36:5]));
                chk("out_tag",  64'(out_tag),  64'(e[4:0]));
            end else begin
                chk("spurious_valid", 64'(out_valid), 64'd0);
            end
        end
        if (flush) q.delete();
        else if (last_in_fire) q.push_back({model_ext(in_imm, in_mode), in_tag});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_dir(input logic [15:0] imm, input logic [1:0] mode,
                            input logic [4:0] tag, input logic [31:0] exp);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        step();
        chk("dir_valid", 64'(out_valid), 64'd1);
        chk("dir_data",  64'(out_data),  64'(exp));
        chk("dir_tag",   64'(out_tag),   64'(tag));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        chk("drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int pushed;
        int cyc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = 16'h0000; in_mode = 2'b00; in_tag = 5'd0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_tag",   64'(out_tag),   64'd0);
        chk("rst_ready", 64'(in_ready),  64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step();

        // Directed extension cases
        push_dir(16'h8000, 2'b00, 5'd3,  32'hFFFF8000);
        push_dir(16'h7FFF, 2'b00, 5'd7,  32'h00007FFF);
        push_dir(16'h8000, 2'b01, 5'd9,  32'h00008000);
        push_dir(16'h1234, 2'b10, 5'd11, 32'h12340000);
        push_dir(16'hFFFF, 2'b11, 5'd13, 32'hFFFFFFFC);
        push_dir(16'h0004, 2'b11, 5'd17, 32'h00000010);
        push_dir(16'h8000, 2'b11, 5'd31, 32'hFFFE0000);
        drain();

        // Backpressure: A, B fill the stage, C waits upstream
        out_ready = 1'b0; in_valid = 1'b1;
        in_imm = 16'hA001; in_mode = 2'b00; in_tag = 5'd1; step();
        in_imm = 16'hB002; in_mode = 2'b01; in_tag = 5'd2; step();
        in_imm = 16'hC003; in_mode = 2'b10; in_tag = 5'd3; step();
        chk("bp_c_held", 64'(last_in_fire), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_a_out", 64'(last_out_fire), 64'd1);
        step();
        chk("bp_c_acc", 64'(last_in_fire), 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp_c_out", 64'(last_out_fire), 64'd1);
        step();

        // Flush while FULL with an entry offered
        out_ready = 1'b0; in_valid = 1'b1;
        in_imm = 16'h1111; in_mode = 2'b00; in_tag = 5'd4; step();
        in_imm = 16'h2222; in_mode = 2'b00; in_tag = 5'd5; step();
        flush = 1'b1; in_imm = 16'h3333; in_tag = 5'd6;
        step();
        chk("fl_not_acc", 64'(last_in_fire), 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid", 64'(out_valid), 64'd0);
        step();
        step();

        // Asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1;
        in_imm = 16'h4444; in_mode = 2'b01; in_tag = 5'd8; step();
        in_imm = 16'h5555; in_mode = 2'b01; in_tag = 5'd9; step();
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_data",  64'(out_data),  64'd0);
        chk("ar_tag",   64'(out_tag),   64'd0);
        chk("ar_ready", 64'(in_ready),  64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("ar_ready_post", 64'(in_ready), 64'd1);

        // Random streaming with random backpressure
        pushed = 0; cyc = 0;
        last_in_fire = 1'b0;
        while (pushed < 200 && cyc < 3000) begin
            if (!in_valid || last_in_fire) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_imm   = 16'($urandom);
                in_mode  = 2'($urandom_range(0, 3));
                in_tag   = 5'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (last_in_fire) pushed++;
            cyc++;
        end
        chk("stream_count", 64'(pushed), 64'd200);
        drain();

        // Full throughput with out_ready held high
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_imm = 16'($urandom); in_mode = 2'($urandom_range(0, 3)); in_tag = 5'($urandom);
            step();
            chk("thru_in", 64'(last_in_fire), 64'd1);
            if (i > 0) chk("thru_out", 64'(last_out_fire), 64'd1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
